shader_ifetch: RTL and testbench
================================

Name: shader_ifetch

Overview:
- Instruction fetch stage directly upstream of shader_core.
- Holds a per-warp program counter (PC) table and picks the next warp round-robin among launched warps.
- Fetches one 32-bit instruction at a time from instruction memory and buffers it in a small FIFO.
- Presents buffered instructions to shader_core on an instruction/instr_valid/instr_ready handshake, tagged with the warp id.

Parameters:
- NUM_WARPS, 16, number of warp contexts (PC table entries); power of 2, max 16.
- FIFO_DEPTH, 4, instruction buffer entries; power of 2, at least 2.
- PC_STEP, 4, byte increment applied to a warp PC after each fetch.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- launch_valid  in  1  request to start a warp
- launch_ready  out  1  launch accepted this cycle
- launch_warp  in  $clog2(NUM_WARPS)  warp to start
- launch_pc  in  32  start address
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch byte address
- imem_gnt  in  1  request accepted
- imem_rvalid  in  1  fetch data valid
- imem_rdata  in  32  fetched instruction
- instruction  out  32  FIFO head instruction
- instr_warp  out  $clog2(NUM_WARPS)  warp id of FIFO head
- instr_valid  out  1  FIFO non-empty
- instr_ready  in  1  downstream accepts the head
- active_warps  out  NUM_WARPS  mask of launched, not-yet-ended warps
- busy  out  1  any warp active, FIFO non-empty, or fetch in flight
- fetch_count  out  32  perf: completed fetches
- stall_cycles  out  32  perf: cycles with instr_valid=1 and instr_ready=0

Behaviour:
- Reset state:
  - All outputs 0; PC table 0; active mask 0; FSM in IDLE.
  - Reset asserted mid-fetch abandons the transaction.
  - An imem_rvalid arriving after reset is ignored, because rvalid is sampled only in WAIT.
- Launch:
  - launch_ready = !active[launch_warp], computed from the registered mask.
  - On launch_valid && launch_ready: PC[launch_warp] <= launch_pc and active bit set, both at the next edge.
  - A warp ending in the same cycle is still seen as active, so its relaunch is refused that cycle.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when any warp is active and (fifo_count + 1) <= FIFO_DEPTH. This credit rule counts the single outstanding fetch.
  - On entering REQ, latch sel_warp and imem_addr <= PC[sel_warp].
  - Warp selection: first active warp at or after (last_served + 1) mod NUM_WARPS.
  - REQ: imem_req=1 and imem_addr held stable until imem_gnt. On gnt -> WAIT at the next edge.
  - WAIT: on imem_rvalid, do all of the following at the next edge, then return to IDLE:
    - push {sel_warp, imem_rdata} into the FIFO;
    - PC[sel_warp] += PC_STEP, modulo 2^32 (wraps);
    - last_served <= sel_warp.
- END handling:
  - If imem_rdata[31:27] == OP_END (5'b11111), clear active[sel_warp] in the same edge.
  - The END instruction itself is still pushed and forwarded.
- Timing:
  - Only one request outstanding at a time.
  - Minimum fetch cycle is 3 clocks (IDLE, REQ with same-cycle gnt, WAIT with same-cycle rvalid).
  - instr_valid rises the cycle after the rvalid edge.
- FIFO:
  - Show-ahead: instruction and instr_warp reflect the head whenever instr_valid=1.
  - Pop on instr_valid && instr_ready.
  - Simultaneous push and pop: count unchanged, data ordered correctly.
  - Overflow is impossible by the credit rule. A pop when empty is a no-op.
- Launch during an active fetch has no effect on the in-flight request.
- busy = (|active_warps) | instr_valid | (state != IDLE).

Optional Feature:
- Macro: SHADER_IFETCH_PERF_EN.
- Defined:
  - fetch_count increments once per completed fetch.
  - stall_cycles increments on each cycle with instr_valid && !instr_ready.
  - Both counters wrap at 2^32 and reset to 0.
- Undefined: both ports tied to 32'h0 and no counter flops are generated.

Decomposition:
- shader_pkg:
  - OP_END constant;
  - opcode field positions (OPC_MSB=31, OPC_LSB=27);
  - warp_id_t typedef;
  - ifetch_entry_t struct {warp_id_t warp; logic [31:0] instr;};
  - ifetch_state_e enum {IDLE, REQ, WAIT}.
- Sub-module shader_ifetch_fifo: synchronous FIFO of ifetch_entry_t, show-ahead, with count output.

Test Plan:
- Launch warp 3 at 0x100; respond gnt and rvalid immediately with 0x0000_1234 -> imem_addr=0x100; instruction=0x1234, instr_warp=3 one cycle after rvalid; next fetch addr 0x104.
- Launch warps 0, 5, 9 together over 3 cycles; hold instr_ready=1 -> fetch order 0, 5, 9, 0, 5, 9; each PC advances by 4 per fetch.
- Hold instr_ready=0 with FIFO_DEPTH=4 -> exactly 4 fetches, then imem_req stays 0; with the perf macro, stall_cycles increments every cycle; release ready -> fetching resumes.
- Warp 2 fetches 0xF800_0000 (END) -> active_warps[2] cleared; END forwarded; launch_ready for warp 2 is 1 from the next cycle; relaunch at 0x200 succeeds.
- Delay imem_gnt by 5 cycles -> imem_req and imem_addr stable throughout; no duplicate push.
- Assert rst_n=0 while in WAIT, then pulse imem_rvalid after release -> no push; all outputs 0; active_warps=0.

Source files
------------

// File: rtl/shader_pkg.sv
`default_nettype none
// ============================================================================
// Module : shader_pkg
// Brief  : Shared types and constants for the shader instruction fetch path.
// Rev    : 1.0 - initial release
// ============================================================================
package shader_pkg;

    localparam int MAX_WARPS = 16;

    // Opcode field and the opcode that terminates a warp
    localparam int         OPC_MSB = 31;
    localparam int         OPC_LSB = 27;
    localparam logic [4:0] OP_END  = 5'b11111;

    typedef logic [$clog2(MAX_WARPS)-1:0] warp_id_t;

    typedef struct packed {
        warp_id_t    warp;
        logic [31:0] instr;
    } ifetch_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } ifetch_state_e;

    function automatic logic is_end_op(input logic [31:0] instr);
        return instr[OPC_MSB:OPC_LSB] == OP_END;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shader_ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module : shader_ifetch_fifo
// Brief  : Show-ahead synchronous FIFO of fetched instructions with occupancy.
// Rev    : 1.0 - initial release
// ============================================================================
module shader_ifetch_fifo
    import shader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  ifetch_entry_t            push_data,
    input  logic                     pop,
    output ifetch_entry_t            head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  c_DEPTH = (PTR_W+1)'(DEPTH);

    ifetch_entry_t    r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && (r_count != c_DEPTH);
    assign w_pop  = pop && (r_count != '0);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head forced to zero when empty so stale storage never leaks out
    assign empty = (r_count == '0);
    assign head  = empty ? '0 : r_mem[r_rd_ptr];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/shader_ifetch.sv
`default_nettype none
// ============================================================================
// Module : shader_ifetch
// Brief  : Round-robin per-warp instruction fetch with a show-ahead buffer.
//          Optional perf counters enabled by SHADER_IFETCH_PERF_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module shader_ifetch
    import shader_pkg::*;
#(
    parameter int NUM_WARPS  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PC_STEP    = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         launch_valid,
    output logic                         launch_ready,
    input  logic [$clog2(NUM_WARPS)-1:0] launch_warp,
    input  logic [31:0]                  launch_pc,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         imem_gnt,
    input  logic                         imem_rvalid,
    input  logic [31:0]                  imem_rdata,
    output logic [31:0]                  instruction,
    output logic [$clog2(NUM_WARPS)-1:0] instr_warp,
    output logic                         instr_valid,
    input  logic                         instr_ready,
    output logic [NUM_WARPS-1:0]         active_warps,
    output logic                         busy,
    output logic [31:0]                  fetch_count,
    output logic [31:0]                  stall_cycles
);

    localparam int WARP_W = $clog2(NUM_WARPS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    ifetch_state_e     r_state;
    ifetch_state_e     w_state_next;
    logic [31:0]       w_pc [NUM_WARPS];
    logic [NUM_WARPS-1:0] w_active;
    logic [WARP_W-1:0] r_sel_warp;
    logic [WARP_W-1:0] r_last_served;
    logic [WARP_W-1:0] w_next_warp;
    logic [WARP_W-1:0] w_idx;
    logic              w_found;
    logic [31:0]       r_addr;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    ifetch_entry_t     w_push_data;
    ifetch_entry_t     w_head;
    logic              w_credit;
    logic              w_fetch_done;
    logic              w_is_end;
    logic              w_launch;
    logic              w_start_req;

    assign launch_ready = !w_active[launch_warp];
    assign w_launch     = launch_valid && launch_ready;
    // In IDLE nothing is outstanding, so one free slot covers the next fetch
    assign w_credit     = (w_fifo_count < CNT_W'(FIFO_DEPTH));
    assign w_fetch_done = (r_state == WAIT) && imem_rvalid;
    assign w_is_end     = is_end_op(imem_rdata);
    assign w_start_req  = (r_state == IDLE) && (w_state_next == REQ);

    // Round-robin pick: first active warp at or after last_served + 1
    always_comb begin
        w_next_warp = r_last_served;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            w_idx = r_last_served + WARP_W'(i);
            if (!w_found && w_active[w_idx]) begin
                w_found     = 1'b1;
                w_next_warp = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if ((|w_active) && w_credit) w_state_next = REQ;
            REQ:     if (imem_gnt)                w_state_next = WAIT;
            WAIT:    if (imem_rvalid)             w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        imem_req = (r_state == REQ);
        busy     = (|w_active) || !w_fifo_empty || (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_warp    <= '0;
            r_addr        <= '0;
            r_last_served <= '0;
        end else begin
            if (w_start_req) begin
                r_sel_warp <= w_next_warp;
                r_addr     <= w_pc[w_next_warp];
            end
            if (w_fetch_done) begin
                r_last_served <= r_sel_warp;
            end
        end
    end

    // A launch only ever targets an inactive warp, so it cannot collide with
    // the fetch completion of the same entry
    for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
        logic [31:0] r_pc;
        logic        r_act;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_pc  <= '0;
                r_act <= 1'b0;
            end else if (w_launch && (launch_warp == WARP_W'(g))) begin
                r_pc  <= launch_pc;
                r_act <= 1'b1;
            end else if (w_fetch_done && (r_sel_warp == WARP_W'(g))) begin
                r_pc <= r_pc + 32'(PC_STEP);
                if (w_is_end) begin
                    r_act <= 1'b0;
                end
            end
        end

        assign w_pc[g]     = r_pc;
        assign w_active[g] = r_act;
    end

    assign w_push_data = '{warp: warp_id_t'(r_sel_warp), instr: imem_rdata};

    shader_ifetch_fifo #(
        .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_fetch_done),
        .push_data (w_push_data),
        .pop       (instr_ready),
        .head      (w_head),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign imem_addr    = r_addr;
    assign instruction  = w_head.instr;
    assign instr_warp   = w_head.warp[WARP_W-1:0];
    assign instr_valid  = !w_fifo_empty;
    assign active_warps = w_active;

`ifdef SHADER_IFETCH_PERF_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_count  <= '0;
            r_stall_cycles <= '0;
        end else begin
            if (w_fetch_done) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (instr_valid && !instr_ready) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign fetch_count  = r_fetch_count;
    assign stall_cycles = r_stall_cycles;
`else
    assign fetch_count  = 32'h0;
    assign stall_cycles = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shader_ifetch.sv
`default_nettype none
// ============================================================================
// Module : tb_shader_ifetch
// Brief  : Directed, table-driven self-checking bench for shader_ifetch.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_shader_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        launch_valid;
    logic        launch_ready;
    logic [3:0]  launch_warp;
    logic [31:0] launch_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [3:0]  instr_warp;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] active_warps;
    logic        busy;
    logic [31:0] fetch_count;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;
    int nfetch = 0;

    always #5 clk = ~clk;

    shader_ifetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .launch_valid (launch_valid),
        .launch_ready (launch_ready),
        .launch_warp  (launch_warp),
        .launch_pc    (launch_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .instr_warp   (instr_warp),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .active_warps (active_warps),
        .busy         (busy),
        .fetch_count  (fetch_count),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        bit          do_launch;
        logic [3:0]  warp;
        logic [31:0] pc;
        logic [31:0] data;
        int          gdly;
        int          rdly;
        logic [31:0] exp_addr;
        logic [15:0] exp_active;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_launch(input logic [3:0] w, input logic [31:0] pc);
        launch_valid = 1'b1;
        launch_warp  = w;
        launch_pc    = pc;
        #1;
        check("launch_ready", 32'(launch_ready), 32'd1);
        @(negedge clk);
        launch_valid = 1'b0;
    endtask

    // Acts as instruction memory for one fetch; also tries an illegal
    // relaunch of the fetching warp in the rvalid cycle
    task automatic serve(input logic [31:0] data, input int gdly, input int rdly,
                         input logic [31:0] exp_addr, input logic [3:0] exp_warp,
                         input bit chk_head);
        int n = 0;
        while (!imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        check("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < gdly; i++) begin
            @(negedge clk);
            check("req_hold", 32'(imem_req), 32'd1);
            check("addr_hold", imem_addr, exp_addr);
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        check("req_drop", 32'(imem_req), 32'd0);
        for (int i = 0; i < rdly; i++) @(negedge clk);
        imem_rvalid  = 1'b1;
        imem_rdata   = data;
        launch_valid = 1'b1;
        launch_warp  = exp_warp;
        launch_pc    = 32'hDEAD_BEE0;
        #1;
        check("relaunch_refused", 32'(launch_ready), 32'd0);
        @(negedge clk);
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        launch_valid = 1'b0;
        nfetch++;
        if (chk_head) begin
            check("head_valid", 32'(instr_valid), 32'd1);
            check("head_instr", instruction, data);
            check("head_warp", 32'(instr_warp), 32'(exp_warp));
        end
    endtask

    task automatic check_perf_fetch();
`ifdef SHADER_IFETCH_PERF_EN
        check("fetch_count", fetch_count, 32'(nfetch));
`else
        check("fetch_count", fetch_count, 32'h0);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rr_addr [6];
        logic [3:0]  rr_warp [6];
        logic [31:0] st_addr [4];
        logic [3:0]  st_warp [4];
        logic [31:0] s0;
        int          n;

        vt[0] = '{1'b1, 4'd3, 32'h0000_0100, 32'h0000_1234, 0, 0, 32'h0000_0100, 16'h0008};
        vt[1] = '{1'b0, 4'd3, 32'h0,         32'hF800_0000, 0, 2, 32'h0000_0104, 16'h0000};
        vt[2] = '{1'b1, 4'd2, 32'hFFFF_FFFC, 32'h0000_00AA, 0, 0, 32'hFFFF_FFFC, 16'h0004};
        vt[3] = '{1'b0, 4'd2, 32'h0,         32'hF800_0001, 2, 0, 32'h0000_0000, 16'h0000};
        vt[4] = '{1'b1, 4'd2, 32'h0000_0200, 32'h0000_5555, 0, 0, 32'h0000_0200, 16'h0004};
        vt[5] = '{1'b0, 4'd2, 32'h0,         32'hFFFF_FFFF, 0, 1, 32'h0000_0204, 16'h0000};

        rr_addr = '{32'h1000, 32'h5000, 32'h9000, 32'h1004, 32'h5004, 32'h9004};
        rr_warp = '{4'd0, 4'd5, 4'd9, 4'd0, 4'd5, 4'd9};
        st_addr = '{32'h1008, 32'h5008, 32'h9008, 32'h100C};
        st_warp = '{4'd0, 4'd5, 4'd9, 4'd0};

        rst_n        = 1'b0;
        launch_valid = 1'b0;
        launch_warp  = 4'd0;
        launch_pc    = 32'h0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        instr_ready  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state; launch_ready follows the empty active mask
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instruction, 32'd0);
        check("rst_warp", 32'(instr_warp), 32'd0);
        check("rst_active", 32'(active_warps), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fetch_count", fetch_count, 32'd0);
        check("rst_stall", stall_cycles, 32'd0);
        check("rst_launch_ready", 32'(launch_ready), 32'd1);

        // Single fetches, END handling, PC wrap and relaunch
        for (int k = 0; k < 6; k++) begin
            if (vt[k].do_launch) begin
                do_launch(vt[k].warp, vt[k].pc);
            end
            serve(vt[k].data, vt[k].gdly, vt[k].rdly, vt[k].exp_addr, vt[k].warp, 1'b1);
            check("active_mask", 32'(active_warps), 32'(vt[k].exp_active));
            #1;
            check("ready_after_fetch", 32'(launch_ready), 32'(!vt[k].exp_active[vt[k].warp]));
            instr_ready = 1'b1;
            @(negedge clk);
            instr_ready = 1'b0;
            check("fifo_drained", 32'(instr_valid), 32'd0);
        end
        check_perf_fetch();

        // Round-robin among three warps with the consumer always ready
        instr_ready = 1'b1;
        do_launch(4'd0, 32'h1000);
        do_launch(4'd5, 32'h5000);
        do_launch(4'd9, 32'h9000);
        check("rr_active", 32'(active_warps), 32'h0221);
        for (int k = 0; k < 6; k++) begin
            serve(32'h0100_0000 + 32'(k), 0, 0, rr_addr[k], rr_warp[k], 1'b1);
        end

        // Backpressure: exactly FIFO_DEPTH fetches, then no request
        @(negedge clk);
        instr_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            serve(32'h2000_0000 + 32'(k), 0, 0, st_addr[k], st_warp[k], 1'b0);
        end
        check("stall_head", instruction, 32'h2000_0000);
        check("stall_head_warp", 32'(instr_warp), 32'd0);
        s0 = stall_cycles;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_no_req", 32'(imem_req), 32'd0);
        end
        check("stall_busy", 32'(busy), 32'd1);
`ifdef SHADER_IFETCH_PERF_EN
        check("stall_cycles_delta", stall_cycles - s0, 32'd10);
`else
        check("stall_cycles_delta", stall_cycles - s0, 32'd0);
`endif
        instr_ready = 1'b1;
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            check("drain_instr", instruction, 32'h2000_0000 + 32'(j));
            check("drain_warp", 32'(instr_warp), 32'(st_warp[j]));
        end
        @(negedge clk);
        check("drain_empty", 32'(instr_valid), 32'd0);

        // Delayed grant, then end all three warps
        serve(32'hF800_0005, 5, 0, 32'h500C, 4'd5, 1'b1);
        @(negedge clk);
        check("no_dup_push", 32'(instr_valid), 32'd0);
        check("end5_active", 32'(active_warps), 32'h0201);
        serve(32'hF800_0009, 0, 0, 32'h900C, 4'd9, 1'b1);
        serve(32'hF800_0000, 0, 0, 32'h1010, 4'd0, 1'b1);
        repeat (3) @(negedge clk);
        check("all_ended", 32'(active_warps), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_req", 32'(imem_req), 32'd0);
        check_perf_fetch();

        // Reset while waiting for rvalid, then a late rvalid
        do_launch(4'd7, 32'h0700);
        n = 0;
        while (!imem_req && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_seq_req", 32'(imem_req), 32'd1);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_active", 32'(active_warps), 32'd0);
        check("mid_rst_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        check("late_rvalid_valid", 32'(instr_valid), 32'd0);
        check("late_rvalid_instr", instruction, 32'd0);
        check("late_rvalid_active", 32'(active_warps), 32'd0);
        check("late_rvalid_busy", 32'(busy), 32'd0);
        check("late_rvalid_req", 32'(imem_req), 32'd0);
        check("late_rvalid_fetch_count", fetch_count, 32'd0);
        check("late_rvalid_stall", stall_cycles, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
